led16_refresh_tick: RTL and testbench
=====================================

// Module: led16_refresh_tick
// PURPOSE
//  Refresh-tick generator for the 16-LED serial shift driver. Emits a one-cycle
//  load strobe (clk_for_led) at a fixed rate; each strobe makes the driver reload
//  and shift out its 16-bit HEXS word. An optional on-demand refresh request is
//  honoured with a minimum spacing, so a 16-bit shift is never cut short.
// PARAMETERS
//  PERIOD   1_000_000  cycles between periodic strobes (10 ms at 100 MHz); >= MIN_GAP
//  MIN_GAP  32         minimum cycles between any two strobes; >= 18 (1 load + 16 shift + 1 idle)
//  CNT_W    $clog2(PERIOD)  counter width (derived localparam, not overridden)
// PORTS
//  clk          in   1      system clock, all logic on rising edge
//  rst          in   1      synchronous reset, active-high
//  en           in   1      count enable; low freezes the counter and blocks strobes
//  refresh_req  in   1      level/pulse request for an immediate refresh strobe
//  clk_for_led  out  1      load strobe to the LED driver, high exactly one cycle
//  cnt          out  CNT_W  current counter value (cycles since last strobe), for debug
// BEHAVIOUR
//  - Registers: cnt (CNT_W), pend (1), clk_for_led (1). All outputs registered.
//  - Reset (rst high at an edge): cnt<=0, pend<=0, clk_for_led<=0. Reset overrides everything.
//  - Each edge with en=1 and rst=0, with fire = (cnt==PERIOD-1) | ((pend|refresh_req) & cnt>=MIN_GAP-1):
//      fire: cnt<=0, clk_for_led<=1, pend<=0
//      else: cnt<=cnt+1, clk_for_led<=0, pend<=pend|refresh_req
//  - Edge with en=0: cnt holds, clk_for_led<=0, pend<=pend|refresh_req (request kept).
//  - Latency: first periodic strobe is sampled high after the PERIOD-th enabled edge
//    following reset release; thereafter one strobe every PERIOD enabled edges.
//  - clk_for_led is never high two consecutive cycles; strobe spacing >= MIN_GAP edges.
//  - Request arriving too early (cnt < MIN_GAP-1) is latched in pend and served on the
//    first edge at which cnt==MIN_GAP-1 (earliest legal point).
//  - Request coinciding with periodic expiry: one strobe only; pend cleared.
//  - Request held high continuously: strobes every MIN_GAP edges.
//  - cnt wraps only via fire; it never exceeds PERIOD-1.
//  - en dropped mid-count: counting resumes from the held value, no strobe lost or duplicated.
//  - Reset mid-count: pending request discarded, full PERIOD restarts.
//  - Elaboration check: PERIOD >= MIN_GAP and MIN_GAP >= 18, else $error.
// TESTING (bench with PERIOD=40, MIN_GAP=20)
//  1 rst 2 cycles, en=1 -> clk_for_led high only after edge 40, 80, 120; cnt 0..39 ramp.
//  2 refresh_req pulse at cnt=5 -> pend=1, strobe after edge where cnt==19; next periodic strobe 40 edges later.
//  3 refresh_req pulse at cnt=25 -> strobe on that very edge, cnt<=0.
//  4 refresh_req held high 100 cycles -> strobes exactly every 20 edges, never back-to-back.
//  5 en=0 for 7 cycles at cnt=30 -> cnt frozen at 30, no strobe; strobe 10 enabled edges after resume.
//  6 rst asserted at cnt=15 with pend=1 -> cnt=0, pend=0, strobe not before 40 edges; req at cnt=39 gives single strobe.

Source files
------------

// File: rtl/led16_refresh_tick.sv
// Refresh-tick generator for the 16-LED serial shift driver.
// Produces a one-cycle load strobe every PERIOD enabled cycles. It also serves
// on-demand refresh requests, but never sooner than MIN_GAP cycles after the
// previous strobe, so the driver always finishes its 16-bit shift first.
module led16_refresh_tick #(
    parameter int PERIOD  = 1_000_000,
    parameter int MIN_GAP = 32,
    localparam int CNT_W  = $clog2(PERIOD)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             refresh_req,
    output logic             clk_for_led,
    output logic [CNT_W-1:0] cnt
);

    // Terminal counts, pre-sized to the counter width so that every compare is
    // width-matched.
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(MIN_GAP - 1);

    // A strobe must leave room for 1 load + 16 shift + 1 idle cycle. The
    // periodic interval cannot be shorter than that minimum spacing.
    if (MIN_GAP < 18) begin : g_badGap
        $error("led16_refresh_tick: MIN_GAP (%0d) must be >= 18", MIN_GAP);
    end
    if (PERIOD < MIN_GAP) begin : g_badPeriod
        $error("led16_refresh_tick: PERIOD (%0d) must be >= MIN_GAP (%0d)", PERIOD, MIN_GAP);
    end

    logic [CNT_W-1:0] r_cnt;
    logic             r_pend;
    logic             r_strobe;

    logic             w_periodDone;
    logic             w_gapOk;
    logic             w_reqLive;
    logic             w_fire;

    // Fire decision: periodic expiry, or an outstanding/new request once the
    // minimum gap has elapsed. A request that coincides with expiry still
    // produces only one strobe, because both sources share this single term.
    always_comb begin
        w_periodDone = (r_cnt == PERIOD_LAST);
        w_gapOk      = (r_cnt >= GAP_LAST);
        w_reqLive    = r_pend | refresh_req;
        w_fire       = w_periodDone | (w_reqLive & w_gapOk);
    end

    // Counter, pending-request latch and strobe register. When en is low the
    // counter freezes and strobes are blocked, but requests are still latched.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_pend   <= 1'b0;
            r_strobe <= 1'b0;
        end else if (en) begin
            if (w_fire) begin
                r_cnt    <= '0;
                r_strobe <= 1'b1;
                r_pend   <= 1'b0;
            end else begin
                r_cnt    <= r_cnt + 1'b1;
                r_strobe <= 1'b0;
                r_pend   <= w_reqLive;
            end
        end else begin
            r_strobe <= 1'b0;
            r_pend   <= w_reqLive;
        end
    end

    assign clk_for_led = r_strobe;
    assign cnt         = r_cnt;

    // The strobe can never repeat on consecutive cycles, because a fire always
    // restarts the counter at zero, below the gap threshold.
    property p_noBackToBack;
        @(posedge clk) disable iff (rst) r_strobe |=> !r_strobe;
    endproperty
    a_noBackToBack: assert property (p_noBackToBack);

    // The counter only wraps through a fire, so it stays inside the period.
    property p_cntInRange;
        @(posedge clk) disable iff (rst) r_cnt <= PERIOD_LAST;
    endproperty
    a_cntInRange: assert property (p_cntInRange);

endmodule

// File: tb/tb_led16_refresh_tick.sv
// Self-checking bench for led16_refresh_tick with PERIOD=40, MIN_GAP=20.
// Inputs change 1 ns after a rising edge, and outputs are sampled at that same point.
module tb_led16_refresh_tick;

    localparam int PERIOD  = 40;
    localparam int MIN_GAP = 20;
    localparam int CNT_W   = 6;

    typedef struct {
        logic             rst;
        logic             en;
        logic             req;
        logic             expStrobe;
        logic [CNT_W-1:0] expCnt;
    } vec_t;

    logic             clk;
    logic             rst;
    logic             en;
    logic             refresh_req;
    logic             clk_for_led;
    logic [CNT_W-1:0] cnt;

    int vecCount;
    int missCount;
    vec_t vecs[$];

    led16_refresh_tick #(
        .PERIOD (PERIOD),
        .MIN_GAP(MIN_GAP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .refresh_req(refresh_req),
        .clk_for_led(clk_for_led),
        .cnt        (cnt)
    );

    // 10 ns free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one set of inputs, let one rising edge pass, then settle 1 ns.
    task automatic applyStimulus(input logic r, input logic e, input logic q);
        rst         = r;
        en          = e;
        refresh_req = q;
        @(posedge clk);
        #1;
    endtask

    // Compare the strobe and the counter against expected values.
    task automatic checkOutput(input string name, input logic expStrobe, input int expCnt);
        vecCount++;
        if (clk_for_led !== expStrobe || cnt !== CNT_W'(expCnt)) begin
            missCount++;
            $display("[TB] FAIL %s: got strobe=%0b cnt=%0d, expected strobe=%0b cnt=%0d",
                     name, clk_for_led, cnt, expStrobe, expCnt);
        end
    endtask

    task automatic addVec(input logic r, input logic e, input logic q,
                          input logic s, input int c);
        vec_t v;
        v.rst       = r;
        v.en        = e;
        v.req       = q;
        v.expStrobe = s;
        v.expCnt    = CNT_W'(c);
        vecs.push_back(v);
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("reset", 1'b0, 0);
    endtask

    task automatic runIdle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        vecCount    = 0;
        missCount   = 0;
        rst         = 1'b1;
        en          = 1'b0;
        refresh_req = 1'b0;

        // Vector table: reset, freeze with a request latched while disabled,
        // then ramp up to the minimum gap, where the latched request is served.
        addVec(1, 1, 0, 0, 0);
        addVec(1, 1, 1, 0, 0);
        addVec(0, 1, 0, 0, 1);
        addVec(0, 0, 1, 0, 1);
        addVec(0, 0, 0, 0, 1);
        for (int c = 2; c <= 19; c++) addVec(0, 1, 0, 0, c);
        addVec(0, 1, 0, 1, 0);
        addVec(0, 1, 0, 0, 1);
        addVec(0, 1, 0, 0, 2);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rst, vecs[i].en, vecs[i].req);
            checkOutput($sformatf("table[%0d]", i), vecs[i].expStrobe, vecs[i].expCnt);
        end

        // Periodic strobes after edges 40, 80 and 120, with a 0..39 ramp.
        doReset();
        for (int k = 1; k <= 120; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0);
            checkOutput($sformatf("periodic edge %0d", k), (k % 40) == 0, k % 40);
        end

        // An early request at cnt=5 is deferred until the edge where cnt==19.
        doReset();
        runIdle(5);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("early req latched", 1'b0, 6);
        for (int e = 1; e <= 14; e++) begin
            applyStimulus(1'b0, 1'b1, 1'b0);
            checkOutput($sformatf("early req e%0d", e), e == 14, (e == 14) ? 0 : 6 + e);
        end
        for (int e = 1; e <= 40; e++) begin
            applyStimulus(1'b0, 1'b1, 1'b0);
            checkOutput($sformatf("after early req e%0d", e), e == 40, e % 40);
        end

        // A late request at cnt=25 fires on that same edge.
        doReset();
        runIdle(25);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("late req fires", 1'b1, 0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("late req next", 1'b0, 1);

        // A request held high gives a strobe exactly every 20 edges.
        doReset();
        for (int k = 1; k <= 100; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b1);
            checkOutput($sformatf("held req edge %0d", k), (k % 20) == 0, k % 20);
        end
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("held req released", 1'b0, 1);

        // With en low at cnt=30 the counter freezes, then it resumes for the remaining 10 edges.
        doReset();
        runIdle(30);
        for (int e = 1; e <= 7; e++) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            checkOutput($sformatf("frozen e%0d", e), 1'b0, 30);
        end
        for (int e = 1; e <= 10; e++) begin
            applyStimulus(1'b0, 1'b1, 1'b0);
            checkOutput($sformatf("resume e%0d", e), e == 10, (e == 10) ? 0 : 30 + e);
        end

        // Reset at cnt=15 with a request pending: the request is dropped and the full period restarts.
        doReset();
        runIdle(10);
        applyStimulus(1'b0, 1'b1, 1'b1);
        runIdle(4);
        checkOutput("pre-reset count", 1'b0, 15);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("mid reset", 1'b0, 0);
        for (int k = 1; k <= 39; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0);
            checkOutput($sformatf("post reset edge %0d", k), 1'b0, k);
        end
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("req at expiry", 1'b1, 0);
        for (int k = 1; k <= 40; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0);
            checkOutput($sformatf("after expiry edge %0d", k), k == 40, k % 40);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
